// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: FSM state encoding, NOP encoding and address width.
package fetch_pkg;
  localparam int          ADDR_W   = 32;
  localparam logic [31:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_FULL = 2'd2
  } fs_state_t;
endpackage

// File: rtl/fetch_buf.sv
// One-entry holding buffer for an instruction word and its address returned during a stall.
module fetch_buf
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              clear,
  input  logic [31:0]       load_inst,
  input  logic [ADDR_W-1:0] load_addr,
  output logic              full,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] addr
);

  always_ff @(posedge clk) begin
    if (rst) begin
      full <= 1'b0;
      inst <= INST_NOP;
      addr <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
      inst <= load_inst;
      addr <= load_addr;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch with a single outstanding memory request, stall buffer and jump flush.
// Define IF_FETCH_MISALIGN_EN to force-align jump targets and pulse misalign_o on unaligned ones.
module if_fetch
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              jump_en_i,
  input  logic              hold_flag_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [31:0]       mem_rdata_i,
  output logic [31:0]       inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_valid_o,
  output logic              misalign_o
);

  fs_state_t         state, state_n;
  logic [ADDR_W-1:0] pc, pc_n, req_addr, req_addr_n;
  logic              discard, discard_n;
  logic [31:0]       inst_n;
  logic [ADDR_W-1:0] inst_addr_n;
  logic              valid_n, mis_n, deliver;
  logic              buf_load, buf_clear, buf_full;
  logic [31:0]       buf_inst;
  logic [ADDR_W-1:0] buf_addr;
  logic [ADDR_W-1:0] jump_tgt;
  logic              jump_mis;

`ifdef IF_FETCH_MISALIGN_EN
  assign jump_tgt = {jump_addr_i[ADDR_W-1:2], 2'b00};
  assign jump_mis = |jump_addr_i[1:0];
`else
  assign jump_tgt = jump_addr_i;
  assign jump_mis = 1'b0;
`endif

  assign mem_req_o  = (state == FS_REQ) && !rst;
  assign mem_addr_o = pc;

  fetch_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .clear     (buf_clear),
    .load_inst (mem_rdata_i),
    .load_addr (req_addr),
    .full      (buf_full),
    .inst      (buf_inst),
    .addr      (buf_addr)
  );

  always_comb begin
    state_n     = state;
    pc_n        = pc;
    req_addr_n  = req_addr;
    discard_n   = discard;
    buf_load    = 1'b0;
    buf_clear   = 1'b0;
    inst_n      = inst_o;
    inst_addr_n = inst_addr_o;
    valid_n     = inst_valid_o;
    mis_n       = 1'b0;
    deliver     = 1'b0;

    case (state)
      FS_REQ: begin
        if (mem_gnt_i) begin
          req_addr_n = pc;
          pc_n       = pc + 32'd4;
          discard_n  = 1'b0;
          state_n    = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (mem_rvalid_i) begin
          if (discard) begin
            discard_n = 1'b0;
            state_n   = FS_REQ;
          end else if (hold_flag_i) begin
            buf_load = 1'b1;
            state_n  = FS_FULL;
          end else begin
            inst_n      = mem_rdata_i;
            inst_addr_n = req_addr;
            deliver     = 1'b1;
            state_n     = FS_REQ;
          end
        end
      end
      FS_FULL: begin
        if (!hold_flag_i && buf_full) begin
          inst_n      = buf_inst;
          inst_addr_n = buf_addr;
          deliver     = 1'b1;
          buf_clear   = 1'b1;
          state_n     = FS_REQ;
        end
      end
      default: state_n = FS_REQ;
    endcase

    if (deliver) begin
      valid_n = 1'b1;
    end else if (!hold_flag_i) begin
      inst_n  = INST_NOP;
      valid_n = 1'b0;
    end

    // A jump flushes everything in flight; an in-flight word is marked for discard.
    if (jump_en_i) begin
      pc_n        = jump_tgt;
      mis_n       = jump_mis;
      inst_n      = INST_NOP;
      inst_addr_n = inst_addr_o;
      valid_n     = 1'b0;
      buf_load    = 1'b0;
      buf_clear   = 1'b1;
      case (state)
        FS_REQ: begin
          state_n   = mem_gnt_i ? FS_WAIT : FS_REQ;
          discard_n = mem_gnt_i;
        end
        FS_WAIT: begin
          state_n   = mem_rvalid_i ? FS_REQ : FS_WAIT;
          discard_n = !mem_rvalid_i;
        end
        default: begin
          state_n   = FS_REQ;
          discard_n = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FS_REQ;
      pc           <= RESET_PC;
      req_addr     <= '0;
      discard      <= 1'b0;
      inst_o       <= INST_NOP;
      inst_addr_o  <= '0;
      inst_valid_o <= 1'b0;
      misalign_o   <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      req_addr     <= req_addr_n;
      discard      <= discard_n;
      inst_o       <= inst_n;
      inst_addr_o  <= inst_addr_n;
      inst_valid_o <= valid_n;
      misalign_o   <= mis_n;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios with literal expectations, then randomized traffic.
module tb_if_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] jump_addr_i = '0;
  logic        jump_en_i = 1'b0;
  logic        hold_flag_i = 1'b0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i = 1'b0;
  logic        mem_rvalid_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic [31:0] inst_o;
  logic [31:0] inst_addr_o;
  logic        inst_valid_o;
  logic        misalign_o;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  // Reference model state: transaction-level view of the fetch unit.
  logic [31:0] m_pc, m_req_addr, m_inst, m_addr, m_buf_inst, m_buf_addr;
  logic        m_out, m_drop, m_buf, m_valid, m_mis;

  // Bench-side memory
  bit          pend;
  int          dly;
  logic [31:0] paddr;

  if_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .jump_addr_i  (jump_addr_i),
    .jump_en_i    (jump_en_i),
    .hold_flag_i  (hold_flag_i),
    .mem_req_o    (mem_req_o),
    .mem_addr_o   (mem_addr_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .inst_o       (inst_o),
    .inst_addr_o  (inst_addr_o),
    .inst_valid_o (inst_valid_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_step();
    logic        req, got;
    logic [31:0] w, wa, tgt;
    if (rst) begin
      m_pc = 32'h0; m_req_addr = 32'h0; m_out = 0; m_drop = 0; m_buf = 0;
      m_inst = NOP; m_addr = 32'h0; m_valid = 0; m_mis = 0;
      return;
    end
    req = !m_out && !m_buf;
    got = 0; w = '0; wa = '0; m_mis = 0;
    if (m_out && mem_rvalid_i) begin
      m_out = 0;
      if (!m_drop && !jump_en_i) begin got = 1; w = mem_rdata_i; wa = m_req_addr; end
      m_drop = 0;
    end else if (m_out && jump_en_i) begin
      m_drop = 1;
    end
    if (req && mem_gnt_i) begin
      m_out = 1; m_drop = jump_en_i; m_req_addr = m_pc; m_pc = m_pc + 32'd4;
    end
    if (jump_en_i) begin
      tgt = jump_addr_i;
`ifdef IF_FETCH_MISALIGN_EN
      m_mis = (tgt[1:0] != 2'b00);
      tgt[1:0] = 2'b00;
`endif
      m_pc = tgt; m_buf = 0; m_inst = NOP; m_valid = 0;
    end else if (m_buf && !hold_flag_i) begin
      m_inst = m_buf_inst; m_addr = m_buf_addr; m_valid = 1; m_buf = 0;
    end else if (got && !hold_flag_i) begin
      m_inst = w; m_addr = wa; m_valid = 1;
    end else if (got) begin
      m_buf = 1; m_buf_inst = w; m_buf_addr = wa;
    end else if (!hold_flag_i) begin
      m_inst = NOP; m_valid = 0;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    chk("mem_req_o", {31'b0, mem_req_o}, {31'b0, !rst && !m_out && !m_buf});
    chk("mem_addr_o", mem_addr_o, m_pc);
    chk("inst_o", inst_o, m_inst);
    chk("inst_addr_o", inst_addr_o, m_addr);
    chk("inst_valid_o", {31'b0, inst_valid_o}, {31'b0, m_valid});
    chk("misalign_o", {31'b0, misalign_o}, {31'b0, m_mis});
  endtask

  task automatic drive(input bit g, input bit rv, input logic [31:0] rd,
                       input bit h, input bit j, input logic [31:0] ja);
    mem_gnt_i = g; mem_rvalid_i = rv; mem_rdata_i = rd;
    hold_flag_i = h; jump_en_i = j; jump_addr_i = ja;
    cycle();
  endtask

  initial begin
    logic [31:0] r;
    // Reset
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    chk("rst_req", {31'b0, mem_req_o}, 32'd0);
    chk("rst_inst", inst_o, NOP);
    rst = 1'b0;
    #1;
    chk("first_req", {31'b0, mem_req_o}, 32'd1);
    chk("first_addr", mem_addr_o, 32'h0);
    chk("rst_valid", {31'b0, inst_valid_o}, 32'd0);

    // Basic stream with best-case latency
    drive(1, 0, 0, 0, 0, 0);
    chk("wait_noreq", {31'b0, mem_req_o}, 32'd0);
    drive(0, 1, 32'h0000_0093, 0, 0, 0);
    chk("lat_valid", {31'b0, inst_valid_o}, 32'd1);
    chk("lat_inst", inst_o, 32'h0000_0093);
    chk("lat_iaddr", inst_addr_o, 32'h0);
    chk("next_addr4", mem_addr_o, 32'h4);
    drive(1, 0, 0, 0, 0, 0);
    chk("bubble_inst", inst_o, NOP);
    drive(0, 1, 32'h0000_0293, 0, 0, 0);
    chk("iaddr4", inst_addr_o, 32'h4);
    chk("next_addr8", mem_addr_o, 32'h8);

    // Stall across rvalid
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 1, 32'h0010_0113, 1, 0, 0);
    chk("full_noreq", {31'b0, mem_req_o}, 32'd0);
    chk("full_frozen_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("full_frozen_iaddr", inst_addr_o, 32'h4);
    drive(0, 0, 0, 1, 0, 0);
    chk("full_noreq2", {31'b0, mem_req_o}, 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    chk("unhold_inst", inst_o, 32'h0010_0113);
    chk("unhold_valid", {31'b0, inst_valid_o}, 32'd1);
    chk("unhold_iaddr", inst_addr_o, 32'h8);
    chk("resume_addr", mem_addr_o, 32'hC);

    // Jump while waiting
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 32'h100);
    chk("jwait_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("jwait_noreq", {31'b0, mem_req_o}, 32'd0);
    drive(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    chk("stale_dropped", {31'b0, inst_valid_o}, 32'd0);
    chk("stale_inst", inst_o, NOP);
    chk("jump_req", {31'b0, mem_req_o}, 32'd1);
    chk("jump_addr", mem_addr_o, 32'h100);

    // Jump with hold while buffer full
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h0000_0055, 1, 0, 0);
    drive(0, 0, 0, 1, 1, 32'h100);
    chk("jfull_inst", inst_o, NOP);
    chk("jfull_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("jfull_req", {31'b0, mem_req_o}, 32'd1);
    chk("jfull_addr", mem_addr_o, 32'h100);

    // PC wrap
    drive(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    chk("wrap_start", mem_addr_o, 32'hFFFF_FFFC);
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 32'h0001_3579, 0, 0, 0);
    chk("wrap_addr", mem_addr_o, 32'h0);
    chk("wrap_iaddr", inst_addr_o, 32'hFFFF_FFFC);

    // Misaligned jump target
    drive(0, 0, 0, 0, 1, 32'h102);
`ifdef IF_FETCH_MISALIGN_EN
    chk("mis_pulse", {31'b0, misalign_o}, 32'd1);
    chk("mis_addr", mem_addr_o, 32'h100);
`else
    chk("mis_tied", {31'b0, misalign_o}, 32'd0);
    chk("mis_addr", mem_addr_o, 32'h102);
`endif
    drive(0, 0, 0, 0, 0, 0);
    chk("mis_end", {31'b0, misalign_o}, 32'd0);

    // Reset mid-transaction, late rvalid dropped
    drive(1, 0, 0, 0, 0, 0);
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    drive(0, 1, 32'h0000_0BAD, 0, 0, 0);
    chk("late_valid", {31'b0, inst_valid_o}, 32'd0);
    chk("late_req", {31'b0, mem_req_o}, 32'd1);
    chk("late_addr", mem_addr_o, 32'h0);

    // Randomized traffic
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    pend = 0; dly = 0; paddr = '0;
    for (int i = 0; i < 4000; i++) begin
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = $urandom;
      if (pend) begin
        if (dly == 0) begin
          mem_rvalid_i = 1; mem_rdata_i = mem_word(paddr); pend = 0;
        end else dly--;
      end else if (mem_req_o && ($urandom % 4 != 0)) begin
        mem_gnt_i = 1; paddr = mem_addr_o; pend = 1; dly = $urandom_range(0, 2);
      end
      hold_flag_i = ($urandom % 3 == 0);
      jump_en_i   = ($urandom % 16 == 0);
      r = $urandom;
      if ($urandom % 2 == 0) r[1:0] = 2'b00;
      jump_addr_i = r;
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
